// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Memory-side responder for the two-bit cache/memory line bus. It accepts
// line-granular READ_LINE / WRITE_LINE requests from the cache controller,
// waits a fixed access latency, then either returns the line as a burst of
// RESPONSE beats or acknowledges a completed write with a single RESPONSE.
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   reset          : asynchronous, active-high; releases the bus at once
//   address        : line address, sampled in the request cycle
//   data           : shared word bus (initiator drives write beats, this
//                    block drives read response beats, Z otherwise)
//   command        : shared command bus; this block only ever drives RESPONSE
//   protocol_error : sticky flag for bus protocol violations, cleared by reset
//
// Storage is a plain array with a registered read port so that it maps onto
// block RAM. The array is never reset.

module mem_responder #(
  parameter int ADDR_SIZE  = 14,
  parameter int DATA_SIZE  = 16,
  parameter int LINE_BEATS = 8,
  parameter int LATENCY    = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] address,
  inout  wire  [DATA_SIZE-1:0] data,
  inout  wire  [1:0]           command,
  output logic                 protocol_error
);

  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int IDX_W  = ADDR_SIZE + BEAT_W;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [1:0] CMD_NOP      = 2'd0;
  localparam logic [1:0] CMD_RESPONSE = 2'd1;
  localparam logic [1:0] CMD_READ     = 2'd2;
  localparam logic [1:0] CMD_WRITE    = 2'd3;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WRITE_RX = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [BEAT_W-1:0]    BEAT_ZERO = '0;
  localparam logic [BEAT_W-1:0]    BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  // The counter is loaded on the edge that finishes the request and the
  // state moves to RESP on the edge that sees it at zero. One more edge is
  // needed before the first beat is sampled, hence LATENCY-2.
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(LATENCY - 2);
  localparam logic [DATA_SIZE-1:0] INIT_KEY  = DATA_SIZE'(16'h5A5A);

  // Power-on contents are word i = i ^ 5A5A. The array holds each word XOR
  // its power-on value, so a RAM that powers up as all zeros already holds
  // the required image and no initialisation pass is needed.
  function automatic logic [DATA_SIZE-1:0] init_word(input logic [IDX_W-1:0] idx);
    return DATA_SIZE'(idx) ^ INIT_KEY;
  endfunction

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [1:0]           state_reg, state_next;
  logic [ADDR_SIZE-1:0] addr_reg, addr_next;
  logic [BEAT_W-1:0]    beat_reg, beat_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 is_write_reg, is_write_next;
  logic                 error_reg, error_next;

  logic                 mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [DATA_SIZE-1:0] mem_wdata;

  logic [BEAT_W-1:0]    rd_beat;
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_SIZE-1:0] rd_raw_reg;
  logic [DATA_SIZE-1:0] rd_key_reg;

  logic                 req_seen;
  logic                 drive_cmd;
  logic                 drive_data;

  assign req_seen = (command == CMD_READ) || (command == CMD_WRITE);

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    beat_next     = beat_reg;
    count_next    = count_reg;
    is_write_next = is_write_reg;
    error_next    = error_reg;
    mem_we        = 1'b0;
    mem_widx      = '0;
    mem_wdata     = '0;

    case (state_reg)
      S_IDLE: begin
        if (command == CMD_READ) begin
          addr_next     = address;
          is_write_next = 1'b0;
          beat_next     = BEAT_ZERO;
          count_next    = CNT_LOAD;
          state_next    = S_WAIT;
        end else if (command == CMD_WRITE) begin
          // Beat 0 travels with the request itself.
          addr_next  = address;
          mem_we     = 1'b1;
          mem_widx   = {address, BEAT_ZERO};
          mem_wdata  = data;
          beat_next  = BEAT_ONE;
          state_next = S_WRITE_RX;
        end
      end

      S_WRITE_RX: begin
        if (command == CMD_WRITE) begin
          mem_we    = 1'b1;
          mem_widx  = {addr_reg, beat_reg};
          mem_wdata = data;
          beat_next = beat_reg + BEAT_ONE;
          if (beat_reg == BEAT_LAST) begin
            count_next    = CNT_LOAD;
            is_write_next = 1'b1;
            state_next    = S_WAIT;
          end
        end else begin
          // Initiator abandoned the burst: keep what was stored, no ack.
          error_next = 1'b1;
          beat_next  = BEAT_ZERO;
          state_next = S_IDLE;
        end
      end

      S_WAIT: begin
        if (req_seen) begin
          error_next = 1'b1;
        end
        if (count_reg == '0) begin
          state_next = S_RESP;
        end else begin
          count_next = count_reg - CNT_ONE;
        end
      end

      default: begin // S_RESP
        if (req_seen) begin
          error_next = 1'b1;
        end
        if (is_write_reg) begin
          state_next = S_IDLE;
        end else begin
          // Wraps back to zero after the last beat.
          beat_next = beat_reg + BEAT_ONE;
          if (beat_reg == BEAT_LAST) begin
            state_next = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      beat_reg     <= '0;
      count_reg    <= '0;
      is_write_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      beat_reg     <= beat_next;
      count_reg    <= count_next;
      is_write_reg <= is_write_next;
      error_reg    <= error_next;
    end
  end

  // Read address runs one beat ahead of the bus: while waiting it points at
  // beat 0 so the word is in the output register when RESP begins, and
  // during RESP it fetches the beat that will be on the bus next cycle.
  assign rd_beat = (state_reg == S_RESP) ? (beat_reg + BEAT_ONE) : BEAT_ZERO;
  assign rd_idx  = {addr_reg, rd_beat};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata ^ init_word(mem_widx);
    end
    rd_raw_reg <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    rd_key_reg <= init_word(rd_idx);
  end

  // Bus drivers depend only on registered state.
  assign drive_cmd  = (state_reg == S_RESP);
  assign drive_data = drive_cmd && !is_write_reg;

  assign command = drive_cmd  ? CMD_RESPONSE : {2{1'bz}};
  assign data    = drive_data ? (rd_raw_reg ^ rd_key_reg) : {DATA_SIZE{1'bz}};

  assign protocol_error = error_reg;

  // CMD_NOP is part of the bus encoding but needs no action here.
  logic unused_nop;
  assign unused_nop = ^CMD_NOP;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder with a short latency. Requests are issued as a
// linear list of directed steps; every expected bus beat is queued with the
// cycle it must appear in and checked off as the responder produces it.

module tb_mem_responder;

  localparam int LAT = 4;
  localparam int LB  = 8;

  localparam logic [1:0] CMD_NOP      = 2'd0;
  localparam logic [1:0] CMD_RESPONSE = 2'd1;
  localparam logic [1:0] CMD_READ     = 2'd2;
  localparam logic [1:0] CMD_WRITE    = 2'd3;

  typedef struct {
    int          cyc;
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [13:0] tb_addr;
  logic [1:0]  tb_cmd;
  logic        tb_cmd_en;
  logic [15:0] tb_data;
  logic        tb_data_en;
  logic        protocol_error;
  wire  [15:0] data_bus;
  wire  [1:0]  command_bus;

  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];
  logic [15:0] model [int];

  // Released bus lines read as zero (NOP on the command bus).
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pd_data
      pulldown (data_bus[gi]);
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_pd_cmd
      pulldown (command_bus[gi]);
    end
  endgenerate

  assign data_bus    = tb_data_en ? tb_data : 16'bz;
  assign command_bus = tb_cmd_en  ? tb_cmd  : 2'bz;

  mem_responder #(
    .ADDR_SIZE (14),
    .DATA_SIZE (16),
    .LINE_BEATS(LB),
    .LATENCY   (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (tb_addr),
    .data          (data_bus),
    .command       (command_bus),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_word(input int idx);
    logic [31:0] t;
    if (model.exists(idx)) return model[idx];
    t = idx;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and audit the bus for that cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (command_bus === CMD_RESPONSE) begin
      if (sb.size() == 0) begin
        check("unexpected_response", command_bus, CMD_NOP);
      end else begin
        e = sb.pop_front();
        check("resp_cycle", cyc, e.cyc);
        if (e.is_read) begin
          check("resp_data", data_bus, e.data);
          $display("[TB] cycle %0d read beat data=%h expected=%h", cyc, data_bus, e.data);
        end else begin
          check("wresp_data_released", data_bus, 16'h0);
          $display("[TB] cycle %0d write ack", cyc);
        end
      end
    end else begin
      if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        check("resp_missing", command_bus, CMD_RESPONSE);
        void'(sb.pop_front());
      end
      if (!tb_cmd_en)  check("cmd_released", command_bus, CMD_NOP);
      if (!tb_data_en) check("data_released", data_bus, 16'h0);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    tick(); // bus must be released in the cycle after the final RESPONSE
  endtask

  task automatic read_req(input logic [13:0] a);
    exp_t e;
    tb_cmd_en = 1'b1;
    tb_cmd    = CMD_READ;
    tb_addr   = a;
    for (int b = 0; b < LB; b++) begin
      e.cyc     = cyc + LAT + b;
      e.is_read = 1'b1;
      e.data    = model_word(int'(a) * LB + b);
      sb.push_back(e);
    end
    tick();
    tb_cmd_en = 1'b0;
    tb_cmd    = CMD_NOP;
  endtask

  // Sends nbeats write beats; fewer than a full line means the command drops
  // to NOP on the next beat.
  task automatic write_req(input logic [13:0] a, input logic [15:0] base, input int nbeats);
    exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      tb_cmd_en  = 1'b1;
      tb_cmd     = CMD_WRITE;
      tb_addr    = a;
      tb_data_en = 1'b1;
      tb_data    = base + 16'(b);
      model[int'(a) * LB + b] = tb_data;
      if (b == LB - 1) begin
        e.cyc     = cyc + LAT;
        e.is_read = 1'b0;
        e.data    = 16'h0;
        sb.push_back(e);
      end
      tick();
    end
    if (nbeats < LB) begin
      tb_cmd     = CMD_NOP;
      tb_data_en = 1'b0;
      tick();
    end
    tb_cmd_en  = 1'b0;
    tb_data_en = 1'b0;
    tb_cmd     = CMD_NOP;
  endtask

  initial begin
    int c;
    cyc        = 0;
    tests      = 0;
    fails      = 0;
    tb_addr    = '0;
    tb_cmd     = CMD_NOP;
    tb_cmd_en  = 1'b0;
    tb_data    = '0;
    tb_data_en = 1'b0;
    reset      = 1'b1;

    // Reset state
    #1;
    check("reset_cmd", command_bus, CMD_NOP);
    check("reset_data", data_bus, 16'h0);
    check("reset_error", protocol_error, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Read of untouched line 3: power-on image 5A42..5A45
    read_req(14'd3);
    drain(40);

    // Full write of line 5, then read it back and read neighbour line 4
    write_req(14'd5, 16'h1000, LB);
    drain(40);
    read_req(14'd5);
    drain(40);
    read_req(14'd4); // issued the cycle after the final RESPONSE
    drain(40);
    check("error_after_clean_traffic", protocol_error, 1'b0);

    // READ_LINE during WAIT is ignored but flagged
    read_req(14'd7);
    tick();
    tb_cmd_en = 1'b1;
    tb_cmd    = CMD_READ;
    tb_addr   = 14'd9;
    tick();
    tb_cmd_en = 1'b0;
    tb_cmd    = CMD_NOP;
    drain(40);
    check("error_read_in_wait", protocol_error, 1'b1);

    // Write dropped to NOP at beat 3: no ack, beats 0-2 kept, back in IDLE
    write_req(14'd6, 16'h2000, 3);
    for (int i = 0; i < 20; i++) tick();
    check("error_after_abort", protocol_error, 1'b1);
    read_req(14'd6);
    drain(40);

    // Reset while beat 2 of a read is on the bus
    c = cyc;
    read_req(14'd10);
    while (cyc < c + LAT + 2) tick();
    reset = 1'b1;
    #1;
    check("midreset_cmd", command_bus, CMD_NOP);
    check("midreset_data", data_bus, 16'h0);
    check("midreset_error", protocol_error, 1'b0);
    sb.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    read_req(14'd10);
    drain(40);
    check("final_error", protocol_error, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
